// File: rtl/pc_stack_unit_if.sv
// Control-path bundle between the control unit and the PC/return-stack block.
// The master drives the strobes and instruction word; the slave returns the PC and stack status.
interface pc_stack_unit_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
);
   logic               pc_hold;
   logic               pc_inc;
   logic               pc_load;
   logic               pc_call;
   logic               pc_ret;
   logic [INSTR_W-1:0] mbr_out;
   logic [PC_W-1:0]    pc_out;
   logic               ras_empty;
   logic               ras_full;
   logic               ras_ovf;
   logic               ras_unf;

   modport master (
      output pc_hold, pc_inc, pc_load, pc_call, pc_ret, mbr_out,
      input  pc_out, ras_empty, ras_full, ras_ovf, ras_unf
   );

   modport slave (
      input  pc_hold, pc_inc, pc_load, pc_call, pc_ret, mbr_out,
      output pc_out, ras_empty, ras_full, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a LIFO return-address stack. Strobes are resolved by
// fixed priority (hold > ret > call > load > inc); every output is registered.
module pc_stack_unit #(
   parameter int              PC_W      = 8,
   parameter int              INSTR_W   = 16,
   parameter int              TGT_LSB   = 8,
   parameter int              RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_VEC = '0
) (
   input logic              clk,
   input logic              rst,
   pc_stack_unit_if.slave   bus
);

   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_HOLD = 3'd1;
   localparam logic [2:0] OP_RET  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_LOAD = 3'd4;
   localparam logic [2:0] OP_INC  = 3'd5;

   generate
      if (TGT_LSB + PC_W > INSTR_W) begin : g_bad_target
         $error("pc_stack_unit: jump-target field exceeds instruction width");
      end
      if (RAS_DEPTH < 1) begin : g_bad_depth
         $error("pc_stack_unit: RAS_DEPTH must be at least 1");
      end
   endgenerate

   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [PC_W-1:0]  entries_q [RAS_DEPTH];

   logic [2:0]           op_sel;
   logic [PC_W-1:0]      target;
   logic [PC_W-1:0]      pc_plus1;
   logic [CNT_W-1:0]     cnt_m1;
   logic [PC_W-1:0]      top_entry;
   logic                 push_en;
   logic [RAS_DEPTH-1:0] wr_sel;
   logic                 unused_mbr;

   assign target     = bus.mbr_out[TGT_LSB +: PC_W];
   assign unused_mbr = ^bus.mbr_out;
   assign pc_plus1   = pc_q + PC_W'(1);
   assign cnt_m1     = cnt_q - CNT_W'(1);

   always_comb begin
      op_sel = OP_NONE;
      if (bus.pc_hold)      op_sel = OP_HOLD;
      else if (bus.pc_ret)  op_sel = OP_RET;
      else if (bus.pc_call) op_sel = OP_CALL;
      else if (bus.pc_load) op_sel = OP_LOAD;
      else if (bus.pc_inc)  op_sel = OP_INC;
   end

   // Mux rather than a direct index so a non-power-of-two depth never reads out of range.
   always_comb begin
      top_entry = entries_q[0];
      for (int i = 1; i < RAS_DEPTH; i++) begin
         if (cnt_m1 == CNT_W'(i)) top_entry = entries_q[i];
      end
   end

   always_comb begin
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      case (op_sel)
         OP_RET: begin
            if (cnt_q != '0) begin
               pc_d  = top_entry;
               cnt_d = cnt_m1;
            end else begin
               unf_d = 1'b1;
            end
         end
         OP_CALL: begin
            pc_d = target;
            if (cnt_q != CNT_MAX) begin
               push_en = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end
         OP_LOAD: pc_d = target;
         OP_INC:  pc_d = pc_plus1;
         default: ;
      endcase
      empty_d = (cnt_d == '0);
      full_d  = (cnt_d == CNT_MAX);
   end

   // One write strobe per entry; reset suppresses any push issued alongside it.
   generate
      for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_wr_sel
         assign wr_sel[gi] = push_en && !rst && (cnt_q == CNT_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
         if (wr_sel[i]) entries_q[i] <= pc_plus1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_VEC;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.pc_out    = pc_q;
   assign bus.ras_empty = empty_q;
   assign bus.ras_full  = full_q;
   assign bus.ras_ovf   = ovf_q;
   assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed scenarios plus randomized strobe traffic, compared each cycle against
// a queue-based model of the PC and return stack.
module tb_pc_stack_unit;

   localparam int          PC_W  = 8;
   localparam int          DEPTH = 4;
   localparam logic [7:0]  RV    = 8'h10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_stack_unit_if #(.PC_W(PC_W), .INSTR_W(16)) bus_if ();

   pc_stack_unit #(
      .PC_W(PC_W), .INSTR_W(16), .TGT_LSB(8), .RAS_DEPTH(DEPTH), .RESET_VEC(RV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: plain integers and a queue used as the stack.
   int m_pc = 0;
   int m_stack[$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit h, input bit rt, input bit cl,
                             input bit ld, input bit inc, input logic [15:0] mbr);
      int tgt;
      tgt = int'(mbr[15:8]);
      if (r) begin
         m_pc = int'(RV);
         m_stack.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (h) begin
      end else if (rt) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else m_unf = 1'b1;
      end else if (cl) begin
         if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % 256);
         else m_ovf = 1'b1;
         m_pc = tgt;
      end else if (ld) begin
         m_pc = tgt;
      end else if (inc) begin
         m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic step(input string tag, input bit r, input bit h, input bit rt,
                       input bit cl, input bit ld, input bit inc, input logic [15:0] mbr);
      rst            = r;
      bus_if.pc_hold = h;
      bus_if.pc_ret  = rt;
      bus_if.pc_call = cl;
      bus_if.pc_load = ld;
      bus_if.pc_inc  = inc;
      bus_if.mbr_out = mbr;
      @(posedge clk);
      #1;
      model_step(r, h, rt, cl, ld, inc, mbr);
      check({tag, "_pc"},    32'(bus_if.pc_out),    32'(m_pc));
      check({tag, "_empty"}, 32'(bus_if.ras_empty), 32'(m_stack.size() == 0));
      check({tag, "_full"},  32'(bus_if.ras_full),  32'(m_stack.size() == DEPTH));
      check({tag, "_ovf"},   32'(bus_if.ras_ovf),   32'(m_ovf));
      check({tag, "_unf"},   32'(bus_if.ras_unf),   32'(m_unf));
   endtask

   initial begin
      bus_if.pc_hold = 1'b0;
      bus_if.pc_ret  = 1'b0;
      bus_if.pc_call = 1'b0;
      bus_if.pc_load = 1'b0;
      bus_if.pc_inc  = 1'b0;
      bus_if.mbr_out = '0;

      // 1: reset and increments
      step("rst0", 1, 0, 0, 0, 0, 0, 16'h0000);
      step("rst1", 1, 0, 0, 0, 0, 0, 16'h0000);
      check("t1_reset_pc", 32'(bus_if.pc_out), 32'h10);
      for (int i = 0; i < 3; i++) step("t1_inc", 0, 0, 0, 0, 0, 1, 16'h0000);
      check("t1_pc13", 32'(bus_if.pc_out), 32'h13);

      // 2: wrap and load
      step("t2_ldff", 0, 0, 0, 0, 1, 0, 16'hFF00);
      step("t2_wrap", 0, 0, 0, 0, 0, 1, 16'h0000);
      check("t2_pc00", 32'(bus_if.pc_out), 32'h00);
      step("t2_ld5a", 0, 0, 0, 0, 1, 0, 16'h5A00);
      check("t2_pc5a", 32'(bus_if.pc_out), 32'h5A);

      // 3: call and return
      step("t3_ld20", 0, 0, 0, 0, 1, 0, 16'h2000);
      step("t3_call", 0, 0, 0, 1, 0, 0, 16'h8000);
      check("t3_pc80", 32'(bus_if.pc_out), 32'h80);
      step("t3_ret",  0, 0, 1, 0, 0, 0, 16'h0000);
      check("t3_pc21", 32'(bus_if.pc_out), 32'h21);

      // 4: nest to full, overflow, unwind
      step("t4_ld01", 0, 0, 0, 0, 1, 0, 16'h0100);
      step("t4_c1",   0, 0, 0, 1, 0, 0, 16'h1100);
      step("t4_c2",   0, 0, 0, 1, 0, 0, 16'h2100);
      step("t4_c3",   0, 0, 0, 1, 0, 0, 16'h3100);
      step("t4_c4",   0, 0, 0, 1, 0, 0, 16'h4000);
      check("t4_full", 32'(bus_if.ras_full), 32'd1);
      step("t4_c5",   0, 0, 0, 1, 0, 0, 16'h5000);
      check("t4_ovf_pc", 32'(bus_if.pc_out), 32'h50);
      check("t4_ovf",    32'(bus_if.ras_ovf), 32'd1);
      step("t4_r1", 0, 0, 1, 0, 0, 0, 16'h0000);
      check("t4_r32", 32'(bus_if.pc_out), 32'h32);
      step("t4_r2", 0, 0, 1, 0, 0, 0, 16'h0000);
      check("t4_r22", 32'(bus_if.pc_out), 32'h22);
      step("t4_r3", 0, 0, 1, 0, 0, 0, 16'h0000);
      check("t4_r12", 32'(bus_if.pc_out), 32'h12);
      step("t4_r4", 0, 0, 1, 0, 0, 0, 16'h0000);
      check("t4_r02", 32'(bus_if.pc_out), 32'h02);

      // 5: underflow is sticky; hold freezes everything
      step("t5_unf", 0, 0, 1, 0, 0, 0, 16'h0000);
      check("t5_unf_pc", 32'(bus_if.pc_out), 32'h02);
      check("t5_unf",    32'(bus_if.ras_unf), 32'd1);
      step("t5_call", 0, 0, 0, 1, 0, 0, 16'h6000);
      check("t5_unf_sticky", 32'(bus_if.ras_unf), 32'd1);
      step("t5_hold", 0, 1, 0, 1, 0, 0, 16'h7000);
      check("t5_hold_pc", 32'(bus_if.pc_out), 32'h60);

      // 6: priority and mid-nest reset
      step("t6_c",   0, 0, 0, 1, 0, 0, 16'h9000);
      step("t6_pri", 0, 0, 1, 1, 0, 1, 16'hA000);
      check("t6_pri_pc", 32'(bus_if.pc_out), 32'h61);
      step("t6_c2",  0, 0, 0, 1, 0, 0, 16'hB000);
      step("t6_rst", 1, 0, 0, 1, 0, 0, 16'hC000);
      check("t6_rst_pc",    32'(bus_if.pc_out),    32'h10);
      check("t6_rst_empty", 32'(bus_if.ras_empty), 32'd1);

      // Randomized traffic with occasional reset
      for (int n = 0; n < 3000; n++) begin
         bit r, h, rt, cl, ld, inc;
         r   = ($urandom_range(0, 99) == 0);
         h   = ($urandom_range(0, 9) == 0);
         rt  = ($urandom_range(0, 3) == 0);
         cl  = ($urandom_range(0, 2) == 0);
         ld  = ($urandom_range(0, 4) == 0);
         inc = ($urandom_range(0, 1) == 0);
         step("rnd", r, h, rt, cl, ld, inc, 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
